// File: rtl/tone_phase_sched_pkg.sv
// Shared definitions for the tone phase scheduler: register field codes,
// ctrl bit positions and the FSM state encoding.
package tone_phase_sched_pkg;

  // Register field codes (low two bits of reg_addr_in)
  localparam logic [1:0] FLD_FREQ_LO = 2'd0;
  localparam logic [1:0] FLD_FREQ_HI = 2'd1;
  localparam logic [1:0] FLD_CTRL    = 2'd2;

  // ctrl byte bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_WT_LSB = 1;
  localparam int CTRL_CLR    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tone_phase_sched_if.sv
// Host/mixer-facing bundle of the tone phase scheduler.
//
// Handshake semantics: there is no back-pressure anywhere. sample_tick_in and
// reg_write_en_in are single-cycle strobes taken in the cycle they are high.
// slot_valid_out qualifies ch_index_out/lut_addr_out/wave_type_out/mute_out/
// frame_done_out for exactly that cycle; the consumer must take it then.
interface tone_phase_sched_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            sample_tick_in;
  logic            reg_write_en_in;
  logic [CH_W+1:0] reg_addr_in;
  logic [7:0]      reg_data_in;

  logic            slot_valid_out;
  logic [CH_W-1:0] ch_index_out;
  logic [3:0]      lut_addr_out;
  logic [2:0]      wave_type_out;
  logic            mute_out;
  logic            frame_done_out;
  logic            overrun_out;

  // Host / bench side
  modport master (
    output sample_tick_in, reg_write_en_in, reg_addr_in, reg_data_in,
    input  slot_valid_out, ch_index_out, lut_addr_out, wave_type_out,
           mute_out, frame_done_out, overrun_out
  );

  // Scheduler side
  modport slave (
    input  sample_tick_in, reg_write_en_in, reg_addr_in, reg_data_in,
    output slot_valid_out, ch_index_out, lut_addr_out, wave_type_out,
           mute_out, frame_done_out, overrun_out
  );
endinterface

// File: rtl/tone_voice_regs.sv
// Per-voice frequency and control storage with write decode. The phase_clr
// bit of a ctrl write is not stored; it leaves as a one-cycle strobe.
module tone_voice_regs
  import tone_phase_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en_in,
  input  logic [CH_W+1:0]   wr_addr_in,
  input  logic [7:0]        wr_data_in,
  input  logic [CH_W-1:0]   rd_ch_in,
  output logic [15:0]       rd_freq_out,
  output logic [3:0]        rd_ctrl_out,
  output logic [NUM_CH-1:0] clr_strobe_out
);

  logic [NUM_CH-1:0][15:0] freq_q, freq_d;
  logic [NUM_CH-1:0][3:0]  ctrl_q, ctrl_d;
  logic [CH_W-1:0]         wr_voice;
  logic [1:0]              wr_field;
  logic                    unused_data_hi;

  assign wr_voice       = wr_addr_in[CH_W+1:2];
  assign wr_field       = wr_addr_in[1:0];
  assign unused_data_hi = ^wr_data_in[7:5];

  // Write decode; field 3 is reserved and falls through to no update
  always_comb begin
    freq_d         = freq_q;
    ctrl_d         = ctrl_q;
    clr_strobe_out = '0;
    if (wr_en_in) begin
      case (wr_field)
        FLD_FREQ_LO: freq_d[wr_voice][7:0]  = wr_data_in;
        FLD_FREQ_HI: freq_d[wr_voice][15:8] = wr_data_in;
        FLD_CTRL: begin
          ctrl_d[wr_voice]         = wr_data_in[3:0];
          clr_strobe_out[wr_voice] = wr_data_in[CTRL_CLR];
        end
        default: ;
      endcase
    end
  end

  // Register storage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      freq_q <= '0;
      ctrl_q <= '0;
    end else begin
      freq_q <= freq_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Asynchronous read port shows stored values, so a same-cycle write is
  // only seen from the following cycle on
  assign rd_freq_out = freq_q[rd_ch_in];
  assign rd_ctrl_out = ctrl_q[rd_ch_in];

endmodule

// File: rtl/tone_phase_sched.sv
// Time-multiplexed phase accumulator: on each sample tick it visits every
// voice once, one per clock, and presents that voice's LUT address and
// wave type to the wave LUT through registered outputs.
module tone_phase_sched
  import tone_phase_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  tone_phase_sched_if.slave   bus,
  output state_e              state_dbg_out
);

  localparam int CH_W = $clog2(NUM_CH);

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [NUM_CH-1:0][PHASE_W-1:0] phase_q, phase_d;

  logic                         visit_en;
  logic [CH_W-1:0]              visit_ch;
  logic [PHASE_W-1:0]           cur_phase;
  logic [PHASE_W-1:0]           freq_ext;
  logic [15:0]                  rd_freq;
  logic [3:0]                   rd_ctrl;
  logic [NUM_CH-1:0]            clr_strobe;

  logic            slot_valid_q, slot_valid_d;
  logic [CH_W-1:0] ch_index_q, ch_index_d;
  logic [3:0]      lut_addr_q, lut_addr_d;
  logic [2:0]      wave_type_q, wave_type_d;
  logic            mute_q, mute_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;

  tone_voice_regs #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_regs (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .wr_en_in       (bus.reg_write_en_in),
    .wr_addr_in     (bus.reg_addr_in),
    .wr_data_in     (bus.reg_data_in),
    .rd_ch_in       (visit_ch),
    .rd_freq_out    (rd_freq),
    .rd_ctrl_out    (rd_ctrl),
    .clr_strobe_out (clr_strobe)
  );

  // Zero-extends or truncates the 16-bit frequency word to the accumulator
  assign freq_ext  = PHASE_W'(rd_freq);
  assign cur_phase = phase_q[visit_ch];

  // FSM: voice 0 is visited in the tick cycle itself so its registered slot
  // appears one cycle later; ch_q therefore holds the next voice to visit
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    visit_en  = 1'b0;
    visit_ch  = '0;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_tick_in) begin
          visit_en = 1'b1;
          visit_ch = '0;
          ch_d     = CH_W'(1);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        visit_en = 1'b1;
        visit_ch = ch_q;
        if (bus.sample_tick_in) overrun_d = 1'b1;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d    = '0;
          state_d = ST_IDLE;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase update for the visited voice; a phase_clr strobe overrides it
  always_comb begin
    phase_d = phase_q;
    if (visit_en) begin
      if (rd_ctrl[CTRL_EN]) phase_d[visit_ch] = cur_phase + freq_ext;
      else                  phase_d[visit_ch] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr_strobe[c]) phase_d[c] = '0;
    end
  end

  // Slot output values; everything reads zero between slots
  always_comb begin
    slot_valid_d = visit_en;
    ch_index_d   = '0;
    lut_addr_d   = '0;
    wave_type_d  = '0;
    mute_d       = 1'b0;
    frame_done_d = 1'b0;
    if (visit_en) begin
      ch_index_d   = visit_ch;
      lut_addr_d   = cur_phase[PHASE_W-1 -: 4];
      wave_type_d  = rd_ctrl[CTRL_WT_LSB +: 3];
      mute_d       = ~rd_ctrl[CTRL_EN];
      frame_done_d = (visit_ch == CH_W'(NUM_CH - 1));
    end
  end

  // State, phase array and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      phase_q      <= '0;
      slot_valid_q <= 1'b0;
      ch_index_q   <= '0;
      lut_addr_q   <= '0;
      wave_type_q  <= '0;
      mute_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      phase_q      <= phase_d;
      slot_valid_q <= slot_valid_d;
      ch_index_q   <= ch_index_d;
      lut_addr_q   <= lut_addr_d;
      wave_type_q  <= wave_type_d;
      mute_q       <= mute_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.slot_valid_out = slot_valid_q;
  assign bus.ch_index_out   = ch_index_q;
  assign bus.lut_addr_out   = lut_addr_q;
  assign bus.wave_type_out  = wave_type_q;
  assign bus.mute_out       = mute_q;
  assign bus.frame_done_out = frame_done_q;
  assign bus.overrun_out    = overrun_q;
  assign state_dbg_out      = state_q;

endmodule

// File: tb/tb_tone_phase_sched.sv
// Bench for tone_phase_sched: directed frames with hand-computed slots
// pushed into an expected queue, popped by a negedge monitor.
module tb_tone_phase_sched;
  import tone_phase_sched_pkg::*;

  localparam int W = 11; // {ch[1:0], lut[3:0], wt[2:0], mute, done}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_phase_sched_if #(.NUM_CH(4)) bus();
  state_e state_dbg;

  tone_phase_sched #(.NUM_CH(4), .PHASE_W(16)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .bus           (bus),
    .state_dbg_out (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_lut  [4];
  logic [2:0] exp_wt   [4];
  logic       exp_mute [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented slot is compared against the queue head
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.slot_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_slot: got ch %0d with empty expected queue", bus.ch_index_out);
      end else begin
        e = exp_q.pop_front();
        check("slot", {21'd0, bus.ch_index_out, bus.lut_addr_out, bus.wave_type_out,
                       bus.mute_out, bus.frame_done_out}, {21'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic all_mute();
    for (int c = 0; c < 4; c++) begin
      exp_lut[c]  = 4'd0;
      exp_wt[c]   = 3'd0;
      exp_mute[c] = 1'b1;
    end
  endtask

  task automatic push_slot(input int c);
    exp_q.push_back({2'(c), exp_lut[c], exp_wt[c], exp_mute[c], (c == 3)});
  endtask

  task automatic push_frame();
    for (int c = 0; c < 4; c++) push_slot(c);
  endtask

  task automatic tick_only();
    bus.sample_tick_in = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick_in = 1'b0;
  endtask

  task automatic frame();
    push_frame();
    tick_only();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] v, input logic [1:0] f, input logic [7:0] d);
    bus.reg_write_en_in = 1'b1;
    bus.reg_addr_in     = {v, f};
    bus.reg_data_in     = d;
    @(posedge clk); #1;
    bus.reg_write_en_in = 1'b0;
  endtask

  task automatic setup_t5(input logic [3:0] lut1);
    all_mute();
    exp_wt[2]   = 3'd2;
    exp_mute[2] = 1'b0;
    exp_lut[1]  = lut1;
    exp_mute[1] = 1'b0;
  endtask

  // Watchdog bound on the whole run
  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: run did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.sample_tick_in  = 1'b0;
    bus.reg_write_en_in = 1'b0;
    bus.reg_addr_in     = '0;
    bus.reg_data_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_outputs", {18'd0, bus.slot_valid_out, bus.frame_done_out, bus.overrun_out,
                            bus.mute_out, bus.lut_addr_out, bus.wave_type_out,
                            bus.ch_index_out, state_dbg}, 32'd0);

    // 1: plain frame after reset, all voices muted
    all_mute();
    frame();

    // 2: voice 0 at 0x1000 for 20 frames, top nibble walks and wraps
    wr(2'd0, FLD_FREQ_LO, 8'h00);
    wr(2'd0, FLD_FREQ_HI, 8'h10);
    wr(2'd0, FLD_CTRL,    8'h01);
    for (int k = 0; k < 20; k++) begin
      all_mute();
      exp_lut[0]  = 4'(k % 16);
      exp_mute[0] = 1'b0;
      frame();
    end
    wr(2'd0, FLD_CTRL, 8'h10); // disable and clear voice 0

    // 3: second tick two cycles into a frame is dropped and flags overrun
    all_mute();
    push_frame();
    tick_only();
    @(posedge clk); #1;
    bus.sample_tick_in = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("overrun_set", {31'd0, bus.overrun_out}, 32'd1);
    all_mute();
    frame();
    check("overrun_sticky", {31'd0, bus.overrun_out}, 32'd1);

    // 4: ctrl write to voice 2 during its own slot takes effect next frame
    all_mute();
    push_frame();
    tick_only();
    @(posedge clk); #1;
    bus.reg_write_en_in = 1'b1;
    bus.reg_addr_in     = {2'd2, FLD_CTRL};
    bus.reg_data_in     = 8'h05;
    @(posedge clk); #1;
    bus.reg_write_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    all_mute();
    exp_wt[2]   = 3'd2;
    exp_mute[2] = 1'b0;
    frame();

    // 5: voice 1 at 0x4000, then phase_clr restarts it from zero
    wr(2'd1, FLD_FREQ_LO, 8'h00);
    wr(2'd1, FLD_FREQ_HI, 8'h40);
    wr(2'd1, FLD_CTRL,    8'h01);
    setup_t5(4'd0); frame();
    setup_t5(4'd4); frame();
    setup_t5(4'd8); frame();
    wr(2'd1, FLD_CTRL, 8'h11);
    setup_t5(4'd0); frame();
    setup_t5(4'd4); frame();

    // 6: reset during slot 1 aborts the frame; restart begins at voice 0
    setup_t5(4'd8);
    push_slot(0);
    push_slot(1);
    tick_only();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort_valid", {31'd0, bus.slot_valid_out}, 32'd0);
    check("rst_abort_state", {31'd0, state_dbg}, 32'd0);
    check("rst_overrun_clr", {31'd0, bus.overrun_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_more_slots", {31'd0, bus.slot_valid_out}, 32'd0);
    wr(2'd1, FLD_FREQ_HI, 8'h40);
    wr(2'd1, FLD_CTRL,    8'h01);
    all_mute();
    exp_mute[1] = 1'b0;
    exp_lut[1]  = 4'd0;
    frame();
    exp_lut[1]  = 4'd4;
    frame();

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
